hex_uart_sender: RTL

Consumes a 32-bit binary value and transmits it over a UART line as text.
- Output is eight uppercase ASCII hex characters, most significant nibble first, followed by CR (0x0D) and LF (0x0A).
- Frame format is 8N1, LSB first.
- Sits between the numeric result producers and the board's TX pin, and carries its own nibble-to-ASCII conversion.

---
 rtl/hex_uart_sender_if.sv | 22 ++
 rtl/hex_uart_sender.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hex_uart_sender_if.sv
// Value handshake between a numeric result producer and hex_uart_sender.
// The producer drives value_in/value_valid; the sender returns value_ready/busy.
interface hex_uart_sender_if;
   logic [31:0] value_in;
   logic        value_valid;
   logic        value_ready;
   logic        busy;

   modport master (
      output value_in,
      output value_valid,
      input  value_ready,
      input  busy
   );

   modport slave (
      input  value_in,
      input  value_valid,
      output value_ready,
      output busy
   );
endinterface

// File: rtl/hex_uart_sender.sv
// Prints a 32-bit value as eight uppercase hex characters plus CR LF over an
// 8N1 UART line, MSB nibble first, with contiguous frames.
module hex_uart_sender #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic               clk,
   input  logic               rst,
   hex_uart_sender_if.slave   bus,
   output logic               tx
);

   localparam int NUM_CHARS = 10;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] CHAR_LAST = 4'(NUM_CHARS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state;
   logic [BAUD_W-1:0]   baud;
   logic [2:0]          bit_idx;
   logic [3:0]          char_idx;
   logic [31:0]         shadow;
   logic [7:0]          shift;
   logic                ready;
   logic                baud_last;
   logic                start_msg;

   function automatic logic [7:0] char_code(input logic [31:0] word, input logic [3:0] idx);
      logic [3:0] nib;
      nib = 4'(word >> (5'd28 - {idx[2:0], 2'b00}));
      if (idx == 4'd8)
         return 8'h0D;
      else if (idx == 4'd9)
         return 8'h0A;
      else if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};
   endfunction

   assign baud_last = (baud == BAUD_LAST);

   // A waiting value is taken on the edge that ends the final stop bit, so
   // back-to-back messages carry no idle gap and value_ready never pulses.
   assign start_msg = bus.value_valid &&
                      ((state == IDLE) ||
                       (state == STOP && baud_last && char_idx == CHAR_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         char_idx <= '0;
         shadow   <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         ready    <= 1'b1;
      end else if (start_msg) begin
         shadow   <= bus.value_in;
         shift    <= char_code(bus.value_in, 4'd0);
         char_idx <= '0;
         baud     <= '0;
         tx       <= 1'b0;
         ready    <= 1'b0;
         state    <= START;
      end else begin
         case (state)
            IDLE: begin
               tx    <= 1'b1;
               ready <= 1'b1;
            end
            START: begin
               if (baud_last) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (char_idx != CHAR_LAST) begin
                     char_idx <= char_idx + 4'd1;
                     shift    <= char_code(shadow, char_idx + 4'd1);
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     ready <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.value_ready = ready;
   assign bus.busy        = ~ready;

endmodule
